// File: rtl/frame_data_gen.sv
// Frame test-pattern transmitter: back-to-back frames of scrambled zero data
// separated by idle gaps, with single-bit error injection and a frame counter.
// The scrambler reloads its seed whenever no frame is in flight. A paired
// checker that reloads on the falling edge of DataOutEn therefore stays in step.
module frame_data_gen #(
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned GAP_LEN   = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        ErrInject,
    output logic        DataOut,
    output logic        DataOutEn,
    output logic        FrameDone,
    output logic [15:0] FrameCount,
    output logic        Busy
);

    typedef enum logic [1:0] {StIdle, StFrame, StGap} state_e;

    localparam logic [6:0]  Seed    = 7'h7F;
    localparam logic [15:0] LastBit = 16'(FRAME_LEN - 1);
    localparam logic [7:0]  LastGap = 8'(GAP_LEN - 1);

    state_e      state_q, state_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        pend_q, pend_d;
    logic        dout_q, dout_d;
    logic        douten_q, douten_d;
    logic        done_q, done_d;
    logic [15:0] count_q, count_d;
    logic        busy_q, busy_d;
    logic        feedback;

    // x^7 + x^4 + 1 with constant-zero data in: the output bit is the feedback
    assign feedback = lfsr_q[6] ^ lfsr_q[3];

    // Next-state and next-output logic; outputs are registered one cycle
    // behind the state that produces them.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = Seed;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        pend_d    = 1'b0;
        dout_d    = 1'b0;
        douten_d  = 1'b0;
        done_d    = 1'b0;
        count_d   = count_q;
        // Busy is pipelined like the data outputs so it frames the visible
        // activity: it rises with the first bit and falls after the last gap cycle.
        busy_d    = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                gap_cnt_d = '0;
                if (Start) begin
                    state_d = StFrame;
                end
            end
            StFrame: begin
                douten_d  = 1'b1;
                dout_d    = feedback ^ pend_q;
                lfsr_d    = {lfsr_q[5:0], feedback};
                bit_cnt_d = bit_cnt_q + 16'd1;
                if (bit_cnt_q == LastBit) begin
                    // A request landing on the last bit has no bit left to hit
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end else begin
                    // The pending flag is consumed by this bit; a request re-arms it
                    pend_d = ErrInject;
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_q == '0) begin
                    done_d  = 1'b1;
                    count_d = count_q + 16'd1;
                end
                if (gap_cnt_q == LastGap) begin
                    bit_cnt_d = '0;
                    state_d   = Start ? StFrame : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, scrambler, counters and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            lfsr_q    <= Seed;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            pend_q    <= 1'b0;
            dout_q    <= 1'b0;
            douten_q  <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            pend_q    <= pend_d;
            dout_q    <= dout_d;
            douten_q  <= douten_d;
            done_q    <= done_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
        end
    end

    assign DataOut    = dout_q;
    assign DataOutEn  = douten_q;
    assign FrameDone  = done_q;
    assign FrameCount = count_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_frame_data_gen.sv
// Self-checking bench for frame_data_gen: table of single-frame scenarios with
// injection masks, plus hand-written continuous, reset and wrap sequences.
module tb_frame_data_gen;

    localparam int unsigned FL = 16;
    localparam int unsigned GL = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        ErrInject;
    logic        DataOut;
    logic        DataOutEn;
    logic        FrameDone;
    logic [15:0] FrameCount;
    logic        Busy;

    frame_data_gen #(
        .FRAME_LEN(FL),
        .GAP_LEN  (GL)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .ErrInject (ErrInject),
        .DataOut   (DataOut),
        .DataOutEn (DataOutEn),
        .FrameDone (FrameDone),
        .FrameCount(FrameCount),
        .Busy      (Busy)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic          use_inj;
        int            inj_at;   // bit index whose registering edge samples ErrInject
        int            inj_len;
        logic [FL-1:0] mask;     // expected inverted bit positions
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [FL-1:0] exp_q[$];
    int            rise_hist[$];
    logic [FL-1:0] ref_bits;
    logic [FL-1:0] cur_bits;
    logic [FL-1:0] last_frame;
    int            cur_len;
    logic          prev_en;
    int            cyc;
    logic [15:0]   exp_count;
    vec_t          vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference scrambler stream starting from the seed
    function automatic logic [FL-1:0] gen_ref();
        logic [6:0]    s;
        logic [FL-1:0] r;
        logic          fb;
        s = 7'h7F;
        r = '0;
        for (int i = 0; i < FL; i++) begin
            fb   = s[6] ^ s[3];
            r[i] = fb;
            s    = {s[5:0], fb};
        end
        return r;
    endfunction

    // Monitor: collect frame bits, compare each finished frame with the scoreboard
    initial begin
        logic [FL-1:0] m;
        cyc      = 0;
        cur_len  = 0;
        cur_bits = '0;
        prev_en  = 1'b0;
        forever begin
            @(negedge Clock);
            cyc++;
            if (!Reset) begin
                cur_len  = 0;
                cur_bits = '0;
                prev_en  = 1'b0;
            end else begin
                if (DataOutEn) begin
                    if (!prev_en) rise_hist.push_back(cyc);
                    if (cur_len < FL) cur_bits[cur_len] = DataOut;
                    cur_len++;
                end else if (prev_en) begin
                    check("frame_len", cur_len, FL);
                    check("frame_done", {31'd0, FrameDone}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard: got frame %0h, expected no frame", cur_bits);
                    end else begin
                        m = exp_q.pop_front();
                        check("frame_bits", {16'd0, cur_bits}, {16'd0, ref_bits ^ m});
                    end
                    last_frame = cur_bits;
                    cur_len    = 0;
                    cur_bits   = '0;
                end else if (FrameDone) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: got FrameDone 1, expected 0 at cycle %0d", cyc);
                end
                prev_en = DataOutEn;
            end
        end
    end

    // One frame triggered by a single-cycle Start pulse from IDLE
    task automatic run_pulse(input logic use_inj, input int inj_at, input int inj_len,
                             input logic [FL-1:0] mask);
        exp_q.push_back(mask);
        for (int c = 0; c < int'(FL + GL + 3); c++) begin
            Start     = (c == 0);
            ErrInject = use_inj && (c - 1 >= inj_at) && (c - 1 < inj_at + inj_len);
            @(negedge Clock);
        end
        ErrInject = 1'b0;
        exp_count = exp_count + 16'd1;
        check("busy_after_gap", {31'd0, Busy}, 32'd0);
        check("frame_count", {16'd0, FrameCount}, {16'd0, exp_count});
    endtask

    initial begin
        int base;
        vecs[0] = '{1'b0,  0, 0, 16'h0000};
        vecs[1] = '{1'b1, 10, 1, 16'h0800};
        vecs[2] = '{1'b0,  0, 0, 16'h0000};
        vecs[3] = '{1'b1, 15, 1, 16'h0000};  // on last bit: dropped
        vecs[4] = '{1'b1, 17, 2, 16'h0000};  // during gap: ignored
        vecs[5] = '{1'b1,  3, 3, 16'h0070};  // held 3 cycles: 3 bits
        vecs[6] = '{1'b1,  0, 1, 16'h0002};
        vecs[7] = '{1'b1, 14, 1, 16'h8000};
        vecs[8] = '{1'b1, -1, 1, 16'h0000};  // while idle: ignored
        vecs[9] = '{1'b1, 14, 3, 16'h8000};  // straddles frame end

        ref_bits  = gen_ref();
        exp_count = '0;
        Reset     = 1'b0;
        Start     = 1'b0;
        ErrInject = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_dataout", {31'd0, DataOut}, 32'd0);
        check("rst_dataouten", {31'd0, DataOutEn}, 32'd0);
        check("rst_framedone", {31'd0, FrameDone}, 32'd0);
        check("rst_framecount", {16'd0, FrameCount}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);

        // Basic frame with point checks on latency, FrameDone and Busy
        exp_q.push_back('0);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("latency_en_low", {31'd0, DataOutEn}, 32'd0);
        check("latency_busy_low", {31'd0, Busy}, 32'd0);
        @(negedge Clock);
        check("bit0_en", {31'd0, DataOutEn}, 32'd1);
        check("bit0_busy", {31'd0, Busy}, 32'd1);
        check("bit0_data", {31'd0, DataOut}, 32'd0);
        repeat (FL - 1) @(negedge Clock);
        check("last_bit_en", {31'd0, DataOutEn}, 32'd1);
        check("last_bit_nodone", {31'd0, FrameDone}, 32'd0);
        @(negedge Clock);
        check("gap_en_low", {31'd0, DataOutEn}, 32'd0);
        check("done_pulse", {31'd0, FrameDone}, 32'd1);
        check("count_on_done", {16'd0, FrameCount}, 32'd1);
        repeat (GL - 1) @(negedge Clock);
        check("busy_in_gap", {31'd0, Busy}, 32'd1);
        check("done_one_cycle", {31'd0, FrameDone}, 32'd0);
        @(negedge Clock);
        check("busy_dropped", {31'd0, Busy}, 32'd0);
        check("first7_bits", {25'd0, last_frame[6:0]}, {25'd0, 7'b1110000});
        exp_count = 16'd1;

        // Table-driven single frames
        for (int i = 0; i < 10; i++) begin
            run_pulse(vecs[i].use_inj, vecs[i].inj_at, vecs[i].inj_len, vecs[i].mask);
        end

        // Continuous: Start high across three frames
        base = rise_hist.size();
        for (int k = 0; k < 3; k++) exp_q.push_back('0);
        for (int c = 0; c < int'(3 * (FL + GL) + 3); c++) begin
            Start = (c < 45);
            if (c == 30) check("busy_continuous", {31'd0, Busy}, 32'd1);
            @(negedge Clock);
        end
        check("cont_frames", rise_hist.size() - base, 3);
        if (rise_hist.size() - base == 3) begin
            check("period_1", rise_hist[base + 1] - rise_hist[base], FL + GL);
            check("period_2", rise_hist[base + 2] - rise_hist[base + 1], FL + GL);
        end
        exp_count = exp_count + 16'd3;
        check("cont_count", {16'd0, FrameCount}, {16'd0, exp_count});
        check("cont_busy", {31'd0, Busy}, 32'd0);

        // Reset in the middle of a frame
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (11) @(negedge Clock);
        check("pre_reset_en", {31'd0, DataOutEn}, 32'd1);
        Reset = 1'b0;
        #1;
        check("mid_rst_en", {31'd0, DataOutEn}, 32'd0);
        check("mid_rst_data", {31'd0, DataOut}, 32'd0);
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check("mid_rst_count", {16'd0, FrameCount}, 32'd0);
        exp_count = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        run_pulse(1'b0, 0, 0, '0);

        // FrameCount wrap from 16'hFFFF
        force dut.count_q = 16'hFFFF;
        @(negedge Clock);
        release dut.count_q;
        @(negedge Clock);
        check("preload_count", {16'd0, FrameCount}, 32'h0000FFFF);
        exp_count = 16'hFFFF;
        run_pulse(1'b0, 0, 0, '0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
